clock_generation: RTL and testbench
===================================

CLOCK_GENERATION -- requirements
Module: clock_generation

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 16, giving the width of the rate counter and the limit inputs.
REQ-002 SHALL have port sys_dom_i.clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_dom_i.rst_n, input, 1, reset; asynchronous, active-low (sys_dom_i is type common_p::clk_dom).
REQ-004 SHALL have port clock_enable_i, input, 1, level request to run the generated clock.
REQ-005 SHALL have port half_rate_limit_i, input, COUNTER_WIDTH, sys cycles per half period minus one.
REQ-006 SHALL have port quarter_rate_limit_i, input, COUNTER_WIDTH, counter value at mid-phase.
REQ-007 SHALL have port idle_level_i, input, 1, io clock level while idle.
REQ-008 SHALL have port io_clk_o, output, 1, generated clock.
REQ-009 SHALL have port half_rate_elapsed_o, output, 1, 1-cycle pulse on the last sys cycle of each half period.
REQ-010 SHALL have port quarter_rate_elapsed_o, output, 1, 1-cycle pulse at mid-phase.
REQ-011 SHALL have port clock_active_o, output, 1, high while RUNNING or STOPPING.

Function
REQ-012 SHALL implement FSM IDLE, RUNNING, STOPPING (clks_alot_p::clk_gen_state_e).
- IDLE -> RUNNING: clock_enable_i high.
- RUNNING -> STOPPING: clock_enable_i low.
- STOPPING -> RUNNING: never.
- STOPPING -> IDLE: on the return-to-idle toggle.
REQ-013 SHALL latch half_rate_limit_i, quarter_rate_limit_i and idle_level_i on the IDLE->RUNNING edge; input changes while active SHALL be ignored.
REQ-014 SHALL use a latched half limit of 1 when the latched half limit is 0.
REQ-015 SHALL clear the counter on entry to RUNNING and increment it every cycle while active; at counter == limit it SHALL wrap to 0 and toggle io_clk_o on that edge.
REQ-016 SHALL assert half_rate_elapsed_o combinationally in the cycle where counter == limit while active; the period SHALL be 2*(limit+1) sys cycles.
REQ-017 SHALL assert quarter_rate_elapsed_o in the cycle where counter == quarter limit while active; there SHALL be no quarter pulse when quarter limit >= half limit.
REQ-018 SHALL make each cycle start by leaving the idle level; the first toggle SHALL occur limit+1 cycles after entering RUNNING.
REQ-019 SHALL, in STOPPING, keep toggling until the toggle that returns io_clk_o to idle level, then enter IDLE on that same edge; no partial cycles are allowed.
REQ-020 SHALL, in IDLE, register idle_level_i onto io_clk_o (1-cycle latency); both pulses SHALL be low.
REQ-021 SHALL, when clock_enable_i drops and rises again during STOPPING, finish the stop, spend 1 cycle in IDLE, then restart.

Reset
REQ-022 SHALL, while sys_dom_i.rst_n is low, force state IDLE, counter 0, io_clk_o 0, clock_active_o 0, all pulses 0, and latched config 0, immediately, including mid-operation.
REQ-023 SHALL, after reset release, apply the IDLE rules on the first clock edge.

Configuration
REQ-024 SHALL support macro CLKS_ALOT_BURST_COUNT_EN, which adds:
- input cycle_count_i, COUNTER_WIDTH, latched at start;
- output burst_done_o;
- a count of completed full cycles.
REQ-025 SHALL, with the macro defined and a nonzero latched count, enter IDLE on the return-to-idle toggle that completes cycle N, and pulse burst_done_o for 1 cycle on the following cycle; a latched count of 0 SHALL mean free-run.
REQ-026 SHALL, without the macro, omit those ports and that logic and always free-run.

Structure
REQ-027 SHALL place clk_gen_state_e in package clks_alot_p; the generated outputs SHALL feed event_generation unchanged.
REQ-028 SHALL place the counter, wrap and compare logic in sub-module rate_counter.

Verification
REQ-029 Scenario, basic run: limit=3, quarter=1, idle=0, enable at cycle 0 -> active from cycle 1; io_clk rises entering cycle 5 and falls entering cycle 9 (period 8); half pulses at cycles 4, 8, ...; quarter pulses at cycles 2, 6, ...
REQ-030 Scenario, stop: deassert enable mid-high-phase -> io_clk falls on the next wrap, IDLE follows, clock_active_o drops in that same cycle, and there are no further pulses.
REQ-031 Scenario, limit edge cases: limit=0 -> period 4; quarter=5 with limit=3 -> no quarter pulses.
REQ-032 Scenario, idle_level=1 with limit=2 -> io_clk high while idle, first fall after 3 cycles, stop ends high.
REQ-033 Scenario, mid-operation reset: assert rst_n low while RUNNING -> all outputs 0 asynchronously; after release with enable high, clean restart.
REQ-034 Scenario, burst (macro on): count=3, limit=1 -> exactly 3 full cycles (12 sys cycles), burst_done_o pulses once, returns to IDLE.

Source files
------------

// File: rtl/clks_alot_p.sv
// Shared types for the clock generation block.
// clks_alot_p : generator state encoding.
// common_p    : clock/reset domain bundle used on block ports.
package clks_alot_p;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } clk_gen_state_e;

endpackage : clks_alot_p

package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom;

endpackage : common_p

// File: rtl/rate_counter.sv
// Half-period rate counter for the clock generator.
// Counts sys cycles while running, wraps at the half limit and flags the
// mid-phase point. Held at zero while idle so every run starts cleanly.
module rate_counter #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_run,
  input  logic [COUNTER_WIDTH-1:0] i_half_limit,
  input  logic [COUNTER_WIDTH-1:0] i_quarter_limit,
  output logic                     o_wrap,
  output logic                     o_quarter_hit
);

  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     w_wrap;
  logic                     w_quarter_valid;

  // Pulses are combinational so they line up with the cycle holding the value.
  assign w_wrap          = i_run && (r_count == i_half_limit);
  // A mid-phase point at or beyond the wrap point never occurs.
  assign w_quarter_valid = (i_quarter_limit < i_half_limit);
  assign o_wrap          = w_wrap;
  assign o_quarter_hit   = i_run && w_quarter_valid && (r_count == i_quarter_limit);

  // Counter: zero while idle, otherwise count up and wrap at the half limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (!i_run || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + COUNTER_WIDTH'(1);
    end
  end

endmodule : rate_counter

// File: rtl/clock_generation.sv
// Programmable io clock generator.
// Produces io_clk_o from the system clock with a period of 2*(limit+1) sys
// cycles, half/quarter rate pulses, and clean start/stop: every generated
// cycle begins by leaving the idle level and the clock only stops on the
// edge that returns it to the idle level.
// Optional feature macro: CLKS_ALOT_BURST_COUNT_EN adds a burst length
// (cycle_count_i) and a burst_done_o pulse; without it the clock free-runs.
module clock_generation #(
  parameter int COUNTER_WIDTH = 16
) (
  input  common_p::clk_dom         sys_dom_i,
  input  logic                     clock_enable_i,
  input  logic [COUNTER_WIDTH-1:0] half_rate_limit_i,
  input  logic [COUNTER_WIDTH-1:0] quarter_rate_limit_i,
  input  logic                     idle_level_i,
`ifdef CLKS_ALOT_BURST_COUNT_EN
  input  logic [COUNTER_WIDTH-1:0] cycle_count_i,
  output logic                     burst_done_o,
`endif
  output logic                     io_clk_o,
  output logic                     half_rate_elapsed_o,
  output logic                     quarter_rate_elapsed_o,
  output logic                     clock_active_o
);

  import clks_alot_p::*;

  logic                     w_clk;
  logic                     w_rst_n;
  clk_gen_state_e           r_state;
  clk_gen_state_e           w_state_next;
  logic [COUNTER_WIDTH-1:0] r_half_limit;
  logic [COUNTER_WIDTH-1:0] r_quarter_limit;
  logic                     r_idle_level;
  logic                     r_io_clk;
  logic                     w_active;
  logic                     w_start;
  logic                     w_wrap;
  logic                     w_quarter_hit;
  logic                     w_return_toggle;
  logic                     w_burst_hit;

  assign w_clk   = sys_dom_i.clk;
  assign w_rst_n = sys_dom_i.rst_n;

  assign w_active = (r_state != IDLE);
  assign w_start  = (r_state == IDLE) && clock_enable_i;
  // The wrap toggle that brings io_clk back to the latched idle level.
  assign w_return_toggle = w_wrap && (r_io_clk != r_idle_level);

  rate_counter #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_rate_counter (
    .i_clk           (w_clk),
    .i_rst_n         (w_rst_n),
    .i_run           (w_active),
    .i_half_limit    (r_half_limit),
    .i_quarter_limit (r_quarter_limit),
    .o_wrap          (w_wrap),
    .o_quarter_hit   (w_quarter_hit)
  );

`ifdef CLKS_ALOT_BURST_COUNT_EN
  logic [COUNTER_WIDTH-1:0] r_cycle_target;
  logic [COUNTER_WIDTH-1:0] r_cycles_done;
  logic                     r_burst_done;

  // Return toggle completing the requested number of cycles; target 0 free-runs.
  assign w_burst_hit = w_return_toggle && (r_cycle_target != '0) &&
                       (r_cycles_done == (r_cycle_target - COUNTER_WIDTH'(1)));
  assign burst_done_o = r_burst_done;

  // Burst bookkeeping: latch target at start, count completed cycles, flag the end.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cycle_target <= '0;
      r_cycles_done  <= '0;
      r_burst_done   <= 1'b0;
    end else begin
      if (w_start) begin
        r_cycle_target <= cycle_count_i;
        r_cycles_done  <= '0;
      end else if (w_return_toggle) begin
        r_cycles_done <= r_cycles_done + COUNTER_WIDTH'(1);
      end
      r_burst_done <= w_burst_hit;
    end
  end
`else
  assign w_burst_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; stopping only completes on a return-to-idle toggle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (clock_enable_i) begin
          w_state_next = RUNNING;
        end
      end
      RUNNING: begin
        if (w_burst_hit) begin
          w_state_next = IDLE;
        end else if (!clock_enable_i) begin
          w_state_next = STOPPING;
        end
      end
      STOPPING: begin
        if (w_return_toggle) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Configuration is captured once at start; a zero half limit runs as 1.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_half_limit    <= '0;
      r_quarter_limit <= '0;
      r_idle_level    <= 1'b0;
    end else if (w_start) begin
      r_half_limit    <= (half_rate_limit_i == '0) ? COUNTER_WIDTH'(1) : half_rate_limit_i;
      r_quarter_limit <= quarter_rate_limit_i;
      r_idle_level    <= idle_level_i;
    end
  end

  // io clock: follows the idle level input while idle, toggles on each wrap while active.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_io_clk <= 1'b0;
    end else if (r_state == IDLE) begin
      r_io_clk <= idle_level_i;
    end else if (w_wrap) begin
      r_io_clk <= ~r_io_clk;
    end
  end

  assign io_clk_o               = r_io_clk;
  assign half_rate_elapsed_o    = w_wrap;
  assign quarter_rate_elapsed_o = w_quarter_hit;
  assign clock_active_o         = w_active;

endmodule : clock_generation

// File: tb/tb_clock_generation.sv
// Testbench for clock_generation (default build; burst scenario when
// CLKS_ALOT_BURST_COUNT_EN is defined).
module tb_clock_generation;
  import common_p::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  clk_dom       dom;
  logic         en;
  logic         il;
  logic [W-1:0] hl;
  logic [W-1:0] ql;
  logic [W-1:0] cnt;
  logic         io_clk;
  logic         half_p;
  logic         quarter_p;
  logic         active;
  logic         burst_done;

  assign dom.clk   = clk;
  assign dom.rst_n = rst_n;

  clock_generation #(.COUNTER_WIDTH(W)) dut (
    .sys_dom_i              (dom),
    .clock_enable_i         (en),
    .half_rate_limit_i      (hl),
    .quarter_rate_limit_i   (ql),
    .idle_level_i           (il),
`ifdef CLKS_ALOT_BURST_COUNT_EN
    .cycle_count_i          (cnt),
    .burst_done_o           (burst_done),
`endif
    .io_clk_o               (io_clk),
    .half_rate_elapsed_o    (half_p),
    .quarter_rate_elapsed_o (quarter_p),
    .clock_active_o         (active)
  );

`ifndef CLKS_ALOT_BURST_COUNT_EN
  assign burst_done = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [4:0] obs;
  logic [4:0] exp;

  // Reference model: phase arithmetic on cycles elapsed since start.
  bit   m_active;
  bit   m_stop;
  int   m_t;
  int   m_L;
  int   m_Q;
  int   m_n;
  logic m_idle;
  logic m_io_idle;
  logic m_burst;

  task automatic model_reset();
    m_active = 0; m_stop = 0; m_t = 0; m_L = 1; m_Q = 0; m_n = 0;
    m_idle = 1'b0; m_io_idle = 1'b0; m_burst = 1'b0;
  endtask

  // Expected {burst_done, active, quarter, half, io_clk} for the current cycle.
  function automatic logic [4:0] model_out();
    logic [4:0] r;
    int ph;
    r = '0;
    if (m_active) begin
      ph   = m_t % (m_L + 1);
      r[0] = m_idle ^ (((m_t / (m_L + 1)) % 2) == 1);
      r[1] = (ph == m_L);
      r[2] = (m_Q < m_L) && (ph == m_Q);
      r[3] = 1'b1;
    end else begin
      r[0] = m_io_idle;
    end
    r[4] = m_burst;
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs presented.
  task automatic model_edge();
    int p;
    bit ret;
    bit done;
    logic nb;
    nb = 1'b0;
    if (!m_active) begin
      m_io_idle = il;
      if (en) begin
        m_active = 1; m_stop = 0; m_t = 0;
        m_L = (hl == '0) ? 1 : int'(hl);
        m_Q = int'(ql); m_idle = il; m_n = int'(cnt);
      end
    end else begin
      p    = 2 * (m_L + 1);
      ret  = ((m_t % p) == p - 1);
      done = ret && (m_n != 0) && (((m_t + 1) / p) == m_n);
      if (done || (ret && m_stop)) begin
        m_active = 0; m_io_idle = m_idle; nb = done;
      end else begin
        m_t++;
        if (!en) m_stop = 1;
      end
    end
    m_burst = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    en = 1'b0; hl = W'(3); ql = W'(1); il = 1'b1; cnt = '0;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      n_checks++;
      if (obs !== 5'b00000) $display("FAIL reset_hold got=%b expected=00000", obs);
      else n_pass++;
    end
    rst_n = 1'b1;
    tick();
    obs = {burst_done, active, quarter_p, half_p, io_clk};
    n_checks++;
    if (obs !== 5'b00001) $display("FAIL reset_first_edge got=%b expected=00001", obs);
    else n_pass++;
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    int first_rise = -1;
    int first_half = -1;
    int first_quarter = -1;
    hl = W'(3); ql = W'(1); il = 1'b0; tick();
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL basic cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (io_clk === 1'b1 && first_rise < 0) first_rise = k;
      if (half_p === 1'b1 && first_half < 0) first_half = k;
      if (quarter_p === 1'b1 && first_quarter < 0) first_quarter = k;
    end
    n_checks++;
    if (first_rise != 5) $display("FAIL basic_first_rise got=%0d expected=5", first_rise);
    else n_pass++;
    n_checks++;
    if (first_half != 4) $display("FAIL basic_first_half got=%0d expected=4", first_half);
    else n_pass++;
    n_checks++;
    if (first_quarter != 2) $display("FAIL basic_first_quarter got=%0d expected=2", first_quarter);
    else n_pass++;
    $display("test_basic: limit=3 quarter=1 done at cycle %0d", cyc);
  endtask

  task automatic test_stop();
    int halves = 0;
    for (int i = 0; i < 20 && model_out() != 5'b01001; i++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL stop_wait cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
    end
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL stop cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (half_p === 1'b1) halves++;
    end
    n_checks++;
    if (halves != 1) $display("FAIL stop_half_count got=%0d expected=1", halves);
    else n_pass++;
    n_checks++;
    if ({active, io_clk} !== 2'b00) $display("FAIL stop_final got=%b expected=00", {active, io_clk});
    else n_pass++;
    $display("test_stop: done at cycle %0d", cyc);
  endtask

  task automatic test_limits();
    int rise1 = -1;
    int rise2 = -1;
    int quarters = 0;
    logic prev;
    hl = W'(0); ql = W'(3); il = 1'b0; en = 1'b1;
    prev = io_clk;
    for (int k = 1; k <= 20; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL limit0 cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (prev === 1'b0 && io_clk === 1'b1) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev = io_clk;
    end
    n_checks++;
    if (rise2 - rise1 != 4) $display("FAIL limit0_period got=%0d expected=4", rise2 - rise1);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    hl = W'(3); ql = W'(5); en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL quarter_over cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (quarter_p === 1'b1) quarters++;
    end
    n_checks++;
    if (quarters != 0) $display("FAIL quarter_over_count got=%0d expected=0", quarters);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    $display("test_limits: done at cycle %0d", cyc);
  endtask

  task automatic test_idle_high();
    int first_fall = -1;
    hl = W'(2); ql = W'(0); il = 1'b1;
    tick();
    n_checks++;
    if (io_clk !== 1'b1) $display("FAIL idle_high_level got=%b expected=1", io_clk);
    else n_pass++;
    en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL idle_high cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (io_clk === 1'b0 && first_fall < 0) first_fall = k;
    end
    n_checks++;
    if (first_fall != 4) $display("FAIL idle_high_first_fall got=%0d expected=4", first_fall);
    else n_pass++;
    en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL idle_high_stop cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
    end
    n_checks++;
    if ({active, io_clk} !== 2'b01) $display("FAIL idle_high_final got=%b expected=01", {active, io_clk});
    else n_pass++;
    $display("test_idle_high: done at cycle %0d", cyc);
  endtask

  task automatic test_reenable();
    int idle_cycles = 0;
    hl = W'(1); ql = W'(0); il = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL reenable cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (active === 1'b0) idle_cycles++;
    end
    n_checks++;
    if (idle_cycles != 1) $display("FAIL reenable_idle_cycles got=%0d expected=1", idle_cycles);
    else n_pass++;
    $display("test_reenable: done at cycle %0d", cyc);
  endtask

  task automatic test_async_reset();
    hl = W'(2); ql = W'(1); il = 1'b0; en = 1'b1;
    for (int i = 0; i < 20 && model_out() != 5'b01001; i++) tick();
    n_checks++;
    if ({active, io_clk} !== 2'b11) $display("FAIL areset_pre got=%b expected=11", {active, io_clk});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    obs = {burst_done, active, quarter_p, half_p, io_clk};
    n_checks++;
    if (obs !== 5'b00000) $display("FAIL areset_immediate got=%b expected=00000", obs);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL areset_restart cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
    end
    en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    $display("test_async_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      hl = W'($urandom_range(0, 4));
      ql = (hl == '0) ? W'($urandom_range(1, 5)) : W'($urandom_range(0, 5));
      il = 1'($urandom_range(0, 1));
`ifdef CLKS_ALOT_BURST_COUNT_EN
      cnt = W'($urandom_range(0, 3));
`else
      cnt = '0;
`endif
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL random cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
    end
    en = 1'b0; cnt = '0;
    for (int i = 0; i < 30; i++) tick();
    $display("test_random: done at cycle %0d", cyc);
  endtask

`ifdef CLKS_ALOT_BURST_COUNT_EN
  task automatic test_burst();
    int pulses = 0;
    int run_len = 0;
    bit first_run = 1;
    hl = W'(1); ql = W'(0); il = 1'b0; cnt = W'(3); en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 15) en = 1'b0;
      tick();
      obs = {burst_done, active, quarter_p, half_p, io_clk};
      exp = model_out();
      n_checks++;
      if (obs !== exp) $display("FAIL burst cyc=%0d got=%b expected=%b", cyc, obs, exp);
      else n_pass++;
      if (burst_done === 1'b1) pulses++;
      if (active === 1'b1 && first_run) run_len++;
      if (active === 1'b0 && run_len > 0) first_run = 0;
    end
    n_checks++;
    if (pulses != 1) $display("FAIL burst_pulses got=%0d expected=1", pulses);
    else n_pass++;
    n_checks++;
    if (run_len != 12) $display("FAIL burst_length got=%0d expected=12", run_len);
    else n_pass++;
    cnt = '0;
    $display("test_burst: done at cycle %0d", cyc);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stop();
    test_limits();
    test_idle_high();
    test_reenable();
    test_async_reset();
`ifdef CLKS_ALOT_BURST_COUNT_EN
    test_burst();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clock_generation
